// File: rtl/icache_line.sv
// Direct-mapped instruction cache with multi-word lines.
// Lookup is purely combinational. A miss starts a sequential line refill,
// one 32-bit word request outstanding at a time. A flush (fence.i) clears
// every valid bit; a request still in flight is drained and discarded.
module icache_line #(
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic                  instr_out_valid,
  output logic [31:0]           instr_out,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           miss_cnt
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << OFFSET_WIDTH;
  localparam int TAG_LSB   = INDEX_WIDTH + OFFSET_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t                  state;
  logic [LINES-1:0]        valid_q;
  logic [TAG_WIDTH-1:0]    tag_q  [LINES];
  logic [31:0]             data_q [LINES][WORDS];
  logic [INDEX_WIDTH-1:0]  fill_index;
  logic [TAG_WIDTH-1:0]    fill_tag;
  logic [OFFSET_WIDTH-1:0] cnt;

  logic [OFFSET_WIDTH-1:0] pc_word;
  logic [INDEX_WIDTH-1:0]  pc_index;
  logic [TAG_WIDTH-1:0]    pc_tag;
  logic                    hit;
  logic                    word_accept;
  logic                    line_done;
  logic                    unused_pc_bits;

  // Fetch address split; the byte offset within a word is irrelevant.
  assign pc_word        = pc[OFFSET_WIDTH+1:2];
  assign pc_index       = pc[TAG_LSB-1:OFFSET_WIDTH+2];
  assign pc_tag         = pc[ADDR_WIDTH-1:TAG_LSB];
  assign unused_pc_bits = ^pc[1:0];

  // Combinational lookup, independent of the refill FSM.
  assign hit             = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign instr_out_valid = hit;
  assign instr_out       = data_q[pc_index][pc_word];

  // A returned word is kept only while filling and not being flushed.
  assign word_accept = rdy && (state == FILL) && mem_valid && !flush;
  assign line_done   = word_accept && (&cnt);

  // Line storage: data words and tags written as the refill progresses.
  // NOTE: the storage arrays have no reset; valid_q alone says what is live.
  always_ff @(posedge clk) begin
    if (word_accept) data_q[fill_index][cnt] <= mem_data;
    if (line_done)   tag_q[fill_index]       <= fill_tag;
  end

  // Refill FSM, valid bits, request interface and miss counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid_q    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      miss_cnt   <= '0;
      cnt        <= '0;
      fill_index <= '0;
      fill_tag   <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (!hit) begin
            fill_index        <= pc_index;
            fill_tag          <= pc_tag;
            valid_q[pc_index] <= 1'b0;
            mem_addr          <= {pc_tag, pc_index, {(OFFSET_WIDTH + 2){1'b0}}};
            mem_req           <= 1'b1;
            cnt               <= '0;
            miss_cnt          <= miss_cnt + 32'd1;
            state             <= FILL;
          end
        end
        FILL: begin
          if (flush) begin
            // The outstanding word is either returning now (dropped) or
            // must still be drained before a new request may be issued.
            valid_q <= '0;
            mem_req <= 1'b0;
            state   <= mem_valid ? IDLE : DRAIN;
          end else if (mem_valid) begin
            if (&cnt) begin
              valid_q[fill_index] <= 1'b1;
              mem_req             <= 1'b0;
              state               <= IDLE;
            end else begin
              cnt      <= cnt + 1'b1;
              mem_addr <= mem_addr + ADDR_WIDTH'(4);
            end
          end
        end
        DRAIN: begin
          if (flush)     valid_q <= '0;
          if (mem_valid) state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_line.sv
// Directed bench for icache_line: inputs change on the falling edge, outputs
// are compared on the falling edge (or just after a combinational change).
module tb_icache_line;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc;
  logic        flush;
  logic        instr_out_valid;
  logic [31:0] instr_out;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] miss_cnt;

  int vectors     = 0;
  int miscompares = 0;

  icache_line dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .pc              (pc),
    .flush           (flush),
    .instr_out_valid (instr_out_valid),
    .instr_out       (instr_out),
    .mem_valid       (mem_valid),
    .mem_data        (mem_data),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .miss_cnt        (miss_cnt)
  );

  always #5 clk = ~clk;

  // One full clock: the rising edge registers, we return on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory returns one word two cycles after the request is presented.
  task automatic serve_word(input logic [31:0] exp_addr, input logic [31:0] data);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
      $display("FAIL serve_req: mem_req=%b mem_addr=%h, want 1 / %h", mem_req, mem_addr, exp_addr);
      miscompares++;
    end
    mem_valid = 1'b0;
    cyc();
    vectors++;
    if (mem_addr !== exp_addr) begin
      $display("FAIL serve_stable: mem_addr=%h, want %h", mem_addr, exp_addr);
      miscompares++;
    end
    mem_valid = 1'b1;
    mem_data  = data;
    cyc();
    mem_valid = 1'b0;
    mem_data  = '0;
  endtask

  // Serves words first..3 of the line at base with data d0+word.
  task automatic fill_line(input logic [31:0] base, input logic [31:0] d0, input int first);
    for (int w = first; w < 4; w++) serve_word(base + 32'(4 * w), d0 + 32'(w));
    vectors++;
    if (mem_req !== 1'b0) begin
      $display("FAIL fill_done_req: mem_req=%b, want 0", mem_req);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; pc = 32'h100; flush = 1'b0;
    mem_valid = 1'b0; mem_data = '0;
    repeat (2) cyc();
    vectors++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || miss_cnt !== 32'h0 || instr_out_valid !== 1'b0) begin
      $display("FAIL reset_state: req=%b addr=%h cnt=%0d valid=%b, want 0/0/0/0",
               mem_req, mem_addr, miss_cnt, instr_out_valid);
      miscompares++;
    end
    rst = 1'b1;
  endtask

  task automatic test_basic_fill();
    pc = 32'h100;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b0) begin
      $display("FAIL basic_cold_miss: valid=%b, want 0", instr_out_valid);
      miscompares++;
    end
    cyc();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || miss_cnt !== 32'd1) begin
      $display("FAIL basic_req_start: req=%b addr=%h cnt=%0d, want 1/100/1", mem_req, mem_addr, miss_cnt);
      miscompares++;
    end
    vectors++;
    if (instr_out_valid !== 1'b0) begin
      $display("FAIL basic_filling_miss: valid=%b, want 0", instr_out_valid);
      miscompares++;
    end
    fill_line(32'h100, 32'hA0, 0);
    vectors++;
    if (instr_out_valid !== 1'b1 || instr_out !== 32'hA0) begin
      $display("FAIL basic_hit_100: valid=%b data=%h, want 1/a0", instr_out_valid, instr_out);
      miscompares++;
    end
    pc = 32'h108;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b1 || instr_out !== 32'hA2) begin
      $display("FAIL basic_hit_108: valid=%b data=%h, want 1/a2", instr_out_valid, instr_out);
      miscompares++;
    end
    cyc();
    vectors++;
    if (mem_req !== 1'b0 || miss_cnt !== 32'd1) begin
      $display("FAIL basic_no_refill: req=%b cnt=%0d, want 0/1", mem_req, miss_cnt);
      miscompares++;
    end
  endtask

  task automatic test_conflict();
    pc = 32'h200;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b0) begin
      $display("FAIL conflict_miss_200: valid=%b, want 0", instr_out_valid);
      miscompares++;
    end
    cyc();
    vectors++;
    if (mem_addr !== 32'h200 || miss_cnt !== 32'd2) begin
      $display("FAIL conflict_start_200: addr=%h cnt=%0d, want 200/2", mem_addr, miss_cnt);
      miscompares++;
    end
    fill_line(32'h200, 32'hB0, 0);
    pc = 32'h20C;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b1 || instr_out !== 32'hB3) begin
      $display("FAIL conflict_hit_20c: valid=%b data=%h, want 1/b3", instr_out_valid, instr_out);
      miscompares++;
    end
    pc = 32'h100;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b0) begin
      $display("FAIL conflict_evicted: valid=%b, want 0", instr_out_valid);
      miscompares++;
    end
    cyc();
    vectors++;
    if (mem_addr !== 32'h100 || miss_cnt !== 32'd3) begin
      $display("FAIL conflict_refetch: addr=%h cnt=%0d, want 100/3", mem_addr, miss_cnt);
      miscompares++;
    end
    fill_line(32'h100, 32'hA0, 0);
  endtask

  task automatic test_flush_drain();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    vectors++;
    if (instr_out_valid !== 1'b0 || mem_req !== 1'b0) begin
      $display("FAIL idle_flush: valid=%b req=%b, want 0/0", instr_out_valid, mem_req);
      miscompares++;
    end
    cyc();
    vectors++;
    if (mem_addr !== 32'h100 || miss_cnt !== 32'd4) begin
      $display("FAIL drain_start: addr=%h cnt=%0d, want 100/4", mem_addr, miss_cnt);
      miscompares++;
    end
    serve_word(32'h100, 32'hC0);
    serve_word(32'h104, 32'hC1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    vectors++;
    if (mem_req !== 1'b0) begin
      $display("FAIL drain_req_drop: req=%b, want 0", mem_req);
      miscompares++;
    end
    cyc();
    vectors++;
    if (mem_req !== 1'b0 || miss_cnt !== 32'd4) begin
      $display("FAIL drain_wait: req=%b cnt=%0d, want 0/4", mem_req, miss_cnt);
      miscompares++;
    end
    mem_valid = 1'b1;
    mem_data  = 32'hDEAD;
    cyc();
    mem_valid = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || miss_cnt !== 32'd4 || instr_out_valid !== 1'b0) begin
      $display("FAIL drain_discard: req=%b cnt=%0d valid=%b, want 0/4/0", mem_req, miss_cnt, instr_out_valid);
      miscompares++;
    end
    cyc();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || miss_cnt !== 32'd5) begin
      $display("FAIL drain_refetch: req=%b addr=%h cnt=%0d, want 1/100/5", mem_req, mem_addr, miss_cnt);
      miscompares++;
    end
    fill_line(32'h100, 32'hC0, 0);
    pc = 32'h108;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b1 || instr_out !== 32'hC2) begin
      $display("FAIL drain_hit_108: valid=%b data=%h, want 1/c2", instr_out_valid, instr_out);
      miscompares++;
    end
  endtask

  task automatic test_flush_coincident();
    pc = 32'h310;
    cyc();
    vectors++;
    if (mem_addr !== 32'h310 || miss_cnt !== 32'd6) begin
      $display("FAIL coinc_start: addr=%h cnt=%0d, want 310/6", mem_addr, miss_cnt);
      miscompares++;
    end
    serve_word(32'h310, 32'hF0);
    cyc();
    mem_valid = 1'b1;
    mem_data  = 32'hF1;
    flush     = 1'b1;
    cyc();
    mem_valid = 1'b0;
    flush     = 1'b0;
    vectors++;
    if (mem_req !== 1'b0) begin
      $display("FAIL coinc_req_drop: req=%b, want 0", mem_req);
      miscompares++;
    end
    pc = 32'h100;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b0) begin
      $display("FAIL coinc_flushed: valid=%b, want 0", instr_out_valid);
      miscompares++;
    end
    pc = 32'h310;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b0) begin
      $display("FAIL coinc_no_valid: valid=%b, want 0", instr_out_valid);
      miscompares++;
    end
    cyc();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h310 || miss_cnt !== 32'd7) begin
      $display("FAIL coinc_no_drain: req=%b addr=%h cnt=%0d, want 1/310/7", mem_req, mem_addr, miss_cnt);
      miscompares++;
    end
    fill_line(32'h310, 32'hD0, 0);
    pc = 32'h314;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b1 || instr_out !== 32'hD1) begin
      $display("FAIL coinc_hit_314: valid=%b data=%h, want 1/d1", instr_out_valid, instr_out);
      miscompares++;
    end
  endtask

  task automatic test_rdy_stall();
    pc = 32'h400;
    cyc();
    vectors++;
    if (mem_addr !== 32'h400 || miss_cnt !== 32'd8) begin
      $display("FAIL stall_start: addr=%h cnt=%0d, want 400/8", mem_addr, miss_cnt);
      miscompares++;
    end
    serve_word(32'h400, 32'hE0);
    rdy       = 1'b0;
    mem_valid = 1'b1;
    mem_data  = 32'hBAD;
    for (int i = 0; i < 5; i++) begin
      cyc();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h404 || miss_cnt !== 32'd8) begin
        $display("FAIL stall_frozen[%0d]: req=%b addr=%h cnt=%0d, want 1/404/8", i, mem_req, mem_addr, miss_cnt);
        miscompares++;
      end
    end
    rdy       = 1'b1;
    mem_valid = 1'b0;
    fill_line(32'h400, 32'hE0, 1);
    pc = 32'h404;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b1 || instr_out !== 32'hE1) begin
      $display("FAIL stall_hit_404: valid=%b data=%h, want 1/e1", instr_out_valid, instr_out);
      miscompares++;
    end
    pc = 32'h40C;
    #1;
    vectors++;
    if (instr_out !== 32'hE3) begin
      $display("FAIL stall_hit_40c: data=%h, want e3", instr_out);
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    pc = 32'h500;
    cyc();
    serve_word(32'h500, 32'h50);
    pc = 32'h314;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b1 || instr_out !== 32'hD1 || mem_req !== 1'b1) begin
      $display("FAIL reset_other_line_hit: valid=%b data=%h req=%b, want 1/d1/1", instr_out_valid, instr_out, mem_req);
      miscompares++;
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || instr_out_valid !== 1'b0 || miss_cnt !== 32'd0 || mem_addr !== 32'h0) begin
      $display("FAIL async_reset: req=%b valid=%b cnt=%0d addr=%h, want 0/0/0/0",
               mem_req, instr_out_valid, miss_cnt, mem_addr);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (instr_out_valid !== 1'b0) begin
      $display("FAIL reset_cold: valid=%b, want 0", instr_out_valid);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h310 || miss_cnt !== 32'd1) begin
      $display("FAIL reset_first_miss: req=%b addr=%h cnt=%0d, want 1/310/1", mem_req, mem_addr, miss_cnt);
      miscompares++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_fill();
    test_conflict();
    test_flush_drain();
    test_flush_coincident();
    test_rdy_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
